// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter with a small byte FIFO.
// The data/status register pair mirrors the keypad input port.
module uart_tx_port #(
   parameter logic [15:0] BASE_ADDR  = 16'hd004,
   parameter int          CLK_DIV    = 5208,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] address,
   input  logic [15:0] data_out,
   input  logic        memwt,
   output logic [15:0] rd_data,
   output logic        hit,
   output logic        tx,
   output logic        busy
);

   localparam int              PW          = $clog2(FIFO_DEPTH);
   localparam int              CW          = $clog2(CLK_DIV);
   localparam logic [15:0]     STAT_ADDR   = BASE_ADDR + 16'd1;
   localparam logic [CW-1:0]   BAUD_RELOAD = CW'(CLK_DIV - 1);
   localparam logic [PW:0]     FULL_COUNT  = (PW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;
   logic          overflow_r;
   logic [1:0]    state_r;
   logic [CW-1:0] baud_r;
   logic [2:0]    bit_idx_r;
   logic [7:0]    shift_r;
   logic          tx_r;
   logic          busy_r;

   logic          full_s;
   logic          empty_s;
   logic          data_wr_s;
   logic          stat_wr_s;
   logic          baud_zero_s;
   logic          pop_s;
   logic          push_s;
   logic [7:0]    head_s;
   logic          unused_data_s;

   assign full_s        = (count_r == FULL_COUNT);
   assign empty_s       = (count_r == '0);
   assign data_wr_s     = memwt && (address == BASE_ADDR);
   assign stat_wr_s     = memwt && (address == STAT_ADDR);
   assign baud_zero_s   = (baud_r == '0);
   assign head_s        = mem_r[rd_ptr_r];
   assign hit           = (address == BASE_ADDR) || (address == STAT_ADDR);
   assign tx            = tx_r;
   assign busy          = busy_r;
   assign unused_data_s = ^data_out[15:8];

   // A full FIFO still accepts a push when the serialiser pops on the same edge.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         IDLE:    pop_s = !empty_s;
         STOP:    pop_s = baud_zero_s && !empty_s;
         default: pop_s = 1'b0;
      endcase
      push_s = data_wr_s && (!full_s || pop_s);
   end

   // CPU read multiplexer
   always_comb begin
      if (address == STAT_ADDR) begin
         rd_data = {12'h000, overflow_r, busy_r, empty_s, full_s};
      end else if (address == BASE_ADDR) begin
         rd_data = {8'h00, head_s};
      end else begin
         rd_data = 16'h0000;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_out[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + (PW + 1)'(1);
         end else if (pop_s && !push_s) begin
            count_r <= count_r - (PW + 1)'(1);
         end
         if (stat_wr_s) begin
            overflow_r <= 1'b0;
         end else if (data_wr_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Frame serialiser; tx/busy are registered to the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         baud_r    <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  shift_r <= head_s;
                  baud_r  <= BAUD_RELOAD;
                  state_r <= START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  tx_r   <= 1'b1;
                  busy_r <= 1'b0;
               end
            end
            START: begin
               if (baud_zero_s) begin
                  baud_r    <= BAUD_RELOAD;
                  bit_idx_r <= 3'd0;
                  state_r   <= DATA;
                  tx_r      <= shift_r[0];
               end else begin
                  baud_r <= baud_r - CW'(1);
               end
            end
            DATA: begin
               if (baud_zero_s) begin
                  baud_r <= BAUD_RELOAD;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= STOP;
                     tx_r    <= 1'b1;
                  end else begin
                     shift_r   <= {1'b0, shift_r[7:1]};
                     bit_idx_r <= bit_idx_r + 3'd1;
                     tx_r      <= shift_r[1];
                  end
               end else begin
                  baud_r <= baud_r - CW'(1);
               end
            end
            STOP: begin
               if (baud_zero_s) begin
                  if (pop_s) begin
                     shift_r <= head_s;
                     baud_r  <= BAUD_RELOAD;
                     state_r <= START;
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  baud_r <= baud_r - CW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped serial transmitter on the bird CPU data bus.
- It is the output-direction counterpart of the keypad input port, using the same data/status register pair scheme.
- The CPU writes bytes to the data address, which queues them in a small FIFO. The CPU polls the status address for space and busy.
- The block serialises queued bytes as 8N1 frames on a single tx pin. Its read-data output feeds the top-level CPU input multiplexer.

Parameters:
- BASE_ADDR, 16'hd004: data register address. Status register is BASE_ADDR+1.
- CLK_DIV, 5208: clk cycles per bit (50 MHz / 9600 baud). Must be at least 2.
- FIFO_DEPTH, 4: byte queue depth. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- address, input, 16: CPU address bus.
- data_out, input, 16: CPU write data. Only bits [7:0] are used.
- memwt, input, 1: CPU write strobe, sampled on the clk rising edge.
- rd_data, output, 16: read value for the CPU input multiplexer. Combinational on address.
- hit, output, 1: high when address equals BASE_ADDR or BASE_ADDR+1.
- tx, output, 1: serial line. Idles high.
- busy, output, 1: high while a frame is being shifted out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, busy=0.
  - FIFO emptied; read and write pointers and count set to 0.
  - Overflow flag cleared; FSM goes to IDLE; baud counter set to 0.
  - Takes effect immediately, including mid-frame. The partial frame is abandoned and the line returns high.
- Data write (memwt=1, address==BASE_ADDR):
  - If the FIFO is not full, push data_out[7:0] at that edge.
  - If it is full, discard the byte and set the sticky overflow flag.
- Status write (memwt=1, address==BASE_ADDR+1): clears overflow. Written data is ignored.
- Reads (combinational):
  - address==BASE_ADDR+1: rd_data = {12'b0, overflow, busy, empty, full}.
  - address==BASE_ADDR: rd_data = {8'b0, byte at FIFO head}. Reads have no side effect.
  - Any other address: rd_data = 16'h0000.
- Simultaneous push and pop in one cycle: both happen, count is unchanged. This holds even when the FIFO is full; the push is accepted because the pop frees a slot that same edge.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1, busy=0.
    - If the FIFO is non-empty, on the next edge: pop the head into the 8-bit shift register, load the baud counter with CLK_DIV-1, and go to START.
    - A byte written at edge N therefore drives tx low at edge N+1.
  - START:
    - tx=0, busy=1.
    - Baud counter decrements each cycle.
    - At 0: reload CLK_DIV-1, set bit index to 0, go to DATA.
  - DATA:
    - tx = shift register bit 0 (LSB first).
    - At counter 0: shift right and increment the index.
    - After index 7 completes, go to STOP.
  - STOP:
    - tx=1, busy=1.
    - At counter 0, if the FIFO is non-empty: pop and go directly to START on the same edge, with no idle gap (back-to-back frames).
    - Otherwise go to IDLE.
- Each frame lasts exactly 10*CLK_DIV cycles.
- Every bit holds for exactly CLK_DIV cycles.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.
  - full = (count==FIFO_DEPTH).
  - empty = (count==0).
- Writes to the bus at any other address are ignored.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4, BASE_ADDR=16'hd004):
- Reset, then no writes for 50 cycles -> tx=1, busy=0, and a read at 16'hd005 returns 16'h0002.
- Write 16'h00A5 to 16'hd004 at edge N -> tx=0 from edge N+1 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 follow, 4 cycles each, then stop=1.
  - busy drops after 40 cycles.
- Write 5 bytes (11,22,33,44,55) on consecutive cycles while idle -> all 5 are transmitted back-to-back with no idle gap. overflow stays 0, because the first pop frees a slot.
- Write 6 bytes on consecutive cycles -> exactly 5 are sent and the status read shows overflow=1 (bit 3). A write to 16'hd005 clears it to 0.
- Assert rst_n low at cycle 15 of a frame -> tx=1 immediately (asynchronously), the FIFO is empty, and status reads 16'h0002. No further frame is sent after release.
- Read 16'hd004 with 16'h0042 queued behind an active frame -> rd_data=16'h0042. A read at 16'hd006 returns 16'h0000 with hit=0.
